mem_bus_ctrl: RTL and testbench

CPU-side memory interface controller that sits directly upstream of the 256-byte MFA/MFC memory. It accepts one load/store request per transaction from the control unit and latches the address and write data (MAR/MDR). It sequences the asynchronous MFA/MFC handshake on the shared 32-bit tristate data bus and returns read data with a one-cycle Done pulse. Load data is zero- or sign-extended, and timeout and misalignment are reported as errors.

---
 rtl/mem_bus_ctrl_if.sv | 31 +++
 rtl/mem_bus_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between the control unit, the mem_bus_ctrl controller and the MFA/MFC memory.
// The master modport is the controller's view; the slave modport is the CPU and memory side.
interface mem_bus_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              Start;
   logic              RW;
   logic              Byte;
   logic              SignExt;
   logic [ADDR_W-1:0] Addr;
   logic [31:0]       WrData;
   logic [31:0]       RdData;
   logic              Busy;
   logic              Done;
   logic              Err;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemRW;
   logic              MemWordByte;
   logic              MFA;
   logic              MFC;

   modport master (
      input  Start, RW, Byte, SignExt, Addr, WrData, MFC,
      output RdData, Busy, Done, Err, MemAddr, MemRW, MemWordByte, MFA
   );

   modport slave (
      output Start, RW, Byte, SignExt, Addr, WrData, MFC,
      input  RdData, Busy, Done, Err, MemAddr, MemRW, MemWordByte, MFA
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Load/store controller for the MFA/MFC memory: latches MAR/MDR, sequences the strobe
// handshake on the shared tristate bus, and returns extended load data with a Done pulse.
module mem_bus_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   mem_bus_ctrl_if.master bus,
   inout  wire  [31:0]    MemData
);
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, FINISH} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_mar;
   logic [31:0]       r_mdr;
   logic [31:0]       r_rdata;
   logic              r_rw;
   logic              r_byte;
   logic              r_sext;
   logic              r_err;
   logic [7:0]        r_cnt;
   logic              w_misalign;
   logic              w_timeout;
   logic              w_drive;
   logic              w_mfa;
   logic              w_busy;
   logic              w_done;

   function automatic logic [31:0] load_ext(input logic [31:0] d, input logic is_byte,
                                            input logic sext);
      if (!is_byte)
         return d;
      return {(sext ? {24{d[7]}} : 24'h0), d[7:0]};
   endfunction

   assign w_misalign = !bus.Byte && (bus.Addr[1:0] != 2'b00);
   assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_mfa   = 1'b0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      w_drive = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (bus.Start)
               w_next = w_misalign ? FINISH : SETUP;
         end
         SETUP: begin
            w_drive = !r_rw;
            w_next  = STROBE;
         end
         // MFC is deliberately not looked at here: it may still be high from the last access.
         STROBE: begin
            w_drive = !r_rw;
            w_mfa   = 1'b1;
            w_next  = WAIT;
         end
         WAIT: begin
            w_drive = !r_rw;
            w_mfa   = 1'b1;
            if (bus.MFC || w_timeout)
               w_next = FINISH;
         end
         FINISH: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_mar   <= '0;
         r_mdr   <= '0;
         r_rdata <= '0;
         r_rw    <= 1'b1;
         r_byte  <= 1'b0;
         r_sext  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.Start) begin
                  r_mar  <= bus.Addr;
                  r_mdr  <= bus.Byte ? {24'h0, bus.WrData[7:0]} : bus.WrData;
                  r_rw   <= bus.RW;
                  r_byte <= bus.Byte;
                  r_sext <= bus.SignExt;
                  r_err  <= w_misalign;
               end
            end
            // A completing MFC takes priority over a timeout in the same cycle.
            WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (bus.MFC) begin
                  if (r_rw)
                     r_rdata <= load_ext(MemData, r_byte, r_sext);
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign MemData         = w_drive ? r_mdr : 'z;
   assign bus.MemAddr     = r_mar;
   assign bus.MemRW       = r_rw;
   assign bus.MemWordByte = r_byte;
   assign bus.MFA         = w_mfa;
   assign bus.Busy        = w_busy;
   assign bus.Done        = w_done;
   assign bus.Err         = w_done & r_err;
   assign bus.RdData      = r_rdata;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a behavioural big-endian 256-byte MFA/MFC memory.
module tb_mem_bus_ctrl;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   wire  [31:0] MemData;

   int n_chk = 0;
   int n_err = 0;

   mem_bus_ctrl_if #(.ADDR_W(8)) bus ();

   mem_bus_ctrl #(.TIMEOUT(4), .ADDR_W(8)) dut (
      .Clk    (clk),
      .Reset  (rst_n),
      .bus    (bus),
      .MemData(MemData)
   );

   always #5 clk = ~clk;

   // Memory model: samples store data on MFA rise, raises MFC mem_lat cycles later.
   logic [7:0]  mem [256];
   logic        mfa_q   = 1'b0;
   int          lat     = 0;
   int          mem_lat = 1;
   bit          mfc_en  = 1'b1;
   logic [31:0] mem_drv = 32'h0;
   logic        mem_oe  = 1'b0;
   logic [7:0]  ma;

   assign MemData = mem_oe ? mem_drv : 'z;

   always @(negedge clk) begin
      ma = bus.MemAddr;
      if (bus.MFA && !mfa_q) begin
         bus.MFC = 1'b0;
         lat = 0;
         if (!bus.MemRW) begin
            if (bus.MemWordByte)
               mem[ma] = MemData[7:0];
            else
               for (int i = 0; i < 4; i++) mem[ma + 8'(i)] = MemData[31-8*i -: 8];
         end
      end else if (bus.MFA && mfc_en && !bus.MFC) begin
         lat++;
         if (lat >= mem_lat) begin
            if (bus.MemRW) begin
               mem_drv = bus.MemWordByte ? {24'h5A5A5A, mem[ma]}
                                         : {mem[ma], mem[ma+8'd1], mem[ma+8'd2], mem[ma+8'd3]};
               mem_oe  = 1'b1;
            end
            bus.MFC = 1'b1;
         end
      end
      if (!bus.MFA) mem_oe = 1'b0;
      mfa_q = bus.MFA;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit rw, input bit byt, input bit sx, input logic [7:0] a,
                        input logic [31:0] wd);
      bus.Start = 1'b1; bus.RW = rw; bus.Byte = byt; bus.SignExt = sx;
      bus.Addr = a; bus.WrData = wd;
      step();
      bus.Start = 1'b0; bus.Addr = 8'h03; bus.WrData = 32'h0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         if (bus.Done === 1'b1) break;
         step();
      end
   endtask

   task automatic test_reset();
      bus.Start = 1'b0; bus.RW = 1'b1; bus.Byte = 1'b0; bus.SignExt = 1'b0;
      bus.Addr = 8'h0; bus.WrData = 32'h0;
      rst_n = 1'b0;
      repeat (2) step();
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL reset_mfa: got %b want 0", bus.MFA); end
      n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
      n_chk++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.Done); end
      n_chk++; if (bus.Err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.Err); end
      n_chk++; if (bus.RdData !== 32'h0) begin n_err++; $display("FAIL reset_rddata: got %h want 0", bus.RdData); end
      n_chk++; if (bus.MemAddr !== 8'h0) begin n_err++; $display("FAIL reset_memaddr: got %h want 0", bus.MemAddr); end
      n_chk++; if (bus.MemRW !== 1'b1) begin n_err++; $display("FAIL reset_memrw: got %b want 1", bus.MemRW); end
      n_chk++; if (bus.MemWordByte !== 1'b0) begin n_err++; $display("FAIL reset_wordbyte: got %b want 0", bus.MemWordByte); end
      rst_n = 1'b1;
      step();
      n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", bus.Busy); end
   endtask

   task automatic test_word_store();
      mem_lat = 1;
      issue(1'b0, 1'b0, 1'b0, 8'd8, 32'hDEADBEEF);
      n_chk++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL ws_setup_busy: got %b want 1", bus.Busy); end
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL ws_setup_mfa: got %b want 0", bus.MFA); end
      n_chk++; if (MemData !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws_setup_data: got %h want deadbeef", MemData); end
      n_chk++; if (bus.MemAddr !== 8'd8) begin n_err++; $display("FAIL ws_setup_addr: got %h want 08", bus.MemAddr); end
      n_chk++; if (bus.MemRW !== 1'b0) begin n_err++; $display("FAIL ws_setup_rw: got %b want 0", bus.MemRW); end
      step();
      n_chk++; if (bus.MFA !== 1'b1) begin n_err++; $display("FAIL ws_strobe_mfa: got %b want 1", bus.MFA); end
      n_chk++; if (MemData !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws_strobe_data: got %h want deadbeef", MemData); end
      step();
      n_chk++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL ws_wait_done: got %b want 0", bus.Done); end
      step();
      n_chk++; if (bus.Done !== 1'b1) begin n_err++; $display("FAIL ws_done: got %b want 1", bus.Done); end
      n_chk++; if (bus.Err !== 1'b0) begin n_err++; $display("FAIL ws_err: got %b want 0", bus.Err); end
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL ws_done_mfa: got %b want 0", bus.MFA); end
      n_chk++; if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws_mem: got %h want deadbeef", {mem[8], mem[9], mem[10], mem[11]}); end
      step();
      n_chk++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin n_err++; $display("FAIL ws_idle: got busy=%b done=%b want 0 0", bus.Busy, bus.Done); end
   endtask

   task automatic test_word_load();
      mem_lat = 1;
      issue(1'b1, 1'b0, 1'b0, 8'd8, 32'h0);
      n_chk++; if (bus.MemRW !== 1'b1) begin n_err++; $display("FAIL wl_setup_rw: got %b want 1", bus.MemRW); end
      wait_done();
      n_chk++; if (bus.Done !== 1'b1) begin n_err++; $display("FAIL wl_done: got %b want 1", bus.Done); end
      n_chk++; if (bus.Err !== 1'b0) begin n_err++; $display("FAIL wl_err: got %b want 0", bus.Err); end
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL wl_done_mfa: got %b want 0", bus.MFA); end
      n_chk++; if (bus.RdData !== 32'hDEADBEEF) begin n_err++; $display("FAIL wl_rddata: got %h want deadbeef", bus.RdData); end
      step();
   endtask

   task automatic test_byte_access();
      mem_lat = 1;
      issue(1'b0, 1'b1, 1'b0, 8'd255, 32'h12345680);
      n_chk++; if (MemData !== 32'h00000080) begin n_err++; $display("FAIL bs_setup_data: got %h want 00000080", MemData); end
      n_chk++; if (bus.MemWordByte !== 1'b1) begin n_err++; $display("FAIL bs_wordbyte: got %b want 1", bus.MemWordByte); end
      wait_done();
      n_chk++; if (bus.Done !== 1'b1 || bus.Err !== 1'b0) begin n_err++; $display("FAIL bs_done: got done=%b err=%b want 1 0", bus.Done, bus.Err); end
      step();
      n_chk++; if (mem[255] !== 8'h80) begin n_err++; $display("FAIL bs_mem: got %h want 80", mem[255]); end
      mem_lat = 2;
      issue(1'b1, 1'b1, 1'b1, 8'd255, 32'h0);
      wait_done();
      n_chk++; if (bus.RdData !== 32'hFFFFFF80) begin n_err++; $display("FAIL bl_sext: got %h want ffffff80", bus.RdData); end
      step();
      issue(1'b1, 1'b1, 1'b0, 8'd255, 32'h0);
      wait_done();
      n_chk++; if (bus.RdData !== 32'h00000080) begin n_err++; $display("FAIL bl_zext: got %h want 00000080", bus.RdData); end
      step();
   endtask

   task automatic test_misalign();
      issue(1'b1, 1'b0, 1'b0, 8'd6, 32'h0);
      n_chk++; if (bus.Done !== 1'b1) begin n_err++; $display("FAIL mis_done: got %b want 1", bus.Done); end
      n_chk++; if (bus.Err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", bus.Err); end
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL mis_mfa: got %b want 0", bus.MFA); end
      step();
      n_chk++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin n_err++; $display("FAIL mis_idle: got done=%b busy=%b want 0 0", bus.Done, bus.Busy); end
      n_chk++; if (bus.RdData !== 32'h00000080) begin n_err++; $display("FAIL mis_rddata: got %h want 00000080", bus.RdData); end
   endtask

   task automatic test_timeout();
      int done_k;
      int mfa_n;
      done_k = -1;
      mfa_n  = 0;
      mfc_en = 1'b0;
      issue(1'b1, 1'b0, 1'b0, 8'd12, 32'h0);
      for (int k = 0; k < 12; k++) begin
         if (bus.MFA === 1'b1) mfa_n++;
         if (bus.Done === 1'b1) begin done_k = k; break; end
         if (k == 3) begin bus.Start = 1'b1; bus.RW = 1'b0; bus.Byte = 1'b1; bus.Addr = 8'd20; end
         step();
      end
      bus.Start = 1'b0;
      n_chk++; if (done_k !== 6) begin n_err++; $display("FAIL to_latency: got %0d want 6", done_k); end
      n_chk++; if (mfa_n !== 5) begin n_err++; $display("FAIL to_mfa_cycles: got %0d want 5", mfa_n); end
      n_chk++; if (bus.Err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", bus.Err); end
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL to_mfa_drop: got %b want 0", bus.MFA); end
      n_chk++; if (bus.RdData !== 32'h00000080) begin n_err++; $display("FAIL to_rddata: got %h want 00000080", bus.RdData); end
      n_chk++; if (bus.MemAddr !== 8'd12) begin n_err++; $display("FAIL to_start_ignored: got %h want 0c", bus.MemAddr); end
      repeat (2) step();
      n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL to_not_queued: got %b want 0", bus.Busy); end
      mfc_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int dn;
      dn = 0;
      mem_lat = 3;
      issue(1'b0, 1'b0, 1'b0, 8'd16, 32'h11223344);
      repeat (2) step();
      n_chk++; if (bus.MFA !== 1'b1) begin n_err++; $display("FAIL rm_in_wait: got %b want 1", bus.MFA); end
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (bus.MFA !== 1'b0) begin n_err++; $display("FAIL rm_mfa: got %b want 0", bus.MFA); end
      n_chk++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", bus.Busy); end
      n_chk++; if (MemData === 32'h11223344) begin n_err++; $display("FAIL rm_bus_release: got %h want released", MemData); end
      n_chk++; if (bus.MemAddr !== 8'h0) begin n_err++; $display("FAIL rm_memaddr: got %h want 00", bus.MemAddr); end
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.Done === 1'b1) dn++;
      end
      rst_n = 1'b1;
      step();
      n_chk++; if (dn !== 0) begin n_err++; $display("FAIL rm_no_done: got %0d want 0", dn); end
      mem_lat = 1;
      issue(1'b0, 1'b0, 1'b0, 8'd16, 32'hCAFEF00D);
      wait_done();
      n_chk++; if (bus.Done !== 1'b1 || bus.Err !== 1'b0) begin n_err++; $display("FAIL rm_store_done: got done=%b err=%b want 1 0", bus.Done, bus.Err); end
      step();
      n_chk++; if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hCAFEF00D) begin n_err++; $display("FAIL rm_mem: got %h want cafef00d", {mem[16], mem[17], mem[18], mem[19]}); end
      issue(1'b1, 1'b0, 1'b0, 8'd16, 32'h0);
      wait_done();
      n_chk++; if (bus.RdData !== 32'hCAFEF00D) begin n_err++; $display("FAIL rm_load: got %h want cafef00d", bus.RdData); end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_word_store();
      test_word_load();
      test_byte_access();
      test_misalign();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
